// File: rtl/cam_capture.sv
// OV7670 capture front end: samples VSYNC/HREF/data in the pixel-clock domain,
// pairs bytes into RGB444 pixels and streams them to the pixel FIFO with position and error flags.
module cam_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic        i_cam_pclk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_cam_vsync,
  input  logic        i_cam_href,
  input  logic [7:0]  i_cam_data,
  input  logic        i_fifo_full,
  output logic        o_wr,
  output logic [11:0] o_wdata,
  output logic        o_sof,
  output logic        o_eol,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic [15:0] o_frame_cnt,
  output logic        o_err_len,
  output logic        o_err_ovf
);

  // Handshake: o_wr is a one-cycle valid with no ready; the FIFO either takes
  // the pixel or drops it (reported through o_err_ovf). Pixels are never stalled.

  typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_START, ACTIVE} state_t;

  localparam logic [10:0] X_FULL = 11'(H_PIXELS);
  localparam logic [10:0] X_LAST = 11'(H_PIXELS - 1);
  localparam logic [8:0]  Y_LAST = 9'(V_LINES - 1);

  state_t      state, state_next;
  logic        vs_q, vs_qq, hr_q, hr_qq;
  logic [7:0]  d_q;
  logic        phase, in_line;
  logic [3:0]  byte0;
  logic [10:0] x_cnt;
  logic [8:0]  y_cnt;

  logic vs_fall, hr_rise, hr_fall;
  logic enter_active, abort, line_start, byte_store, pix_wr, line_end, frame_done;

  assign vs_fall = vs_qq & ~vs_q;
  assign hr_rise = hr_q & ~hr_qq;
  assign hr_fall = ~hr_q & hr_qq;

  always_comb begin
    state_next   = state;
    enter_active = 1'b0;
    abort        = 1'b0;
    line_start   = 1'b0;
    byte_store   = 1'b0;
    pix_wr       = 1'b0;
    line_end     = 1'b0;
    frame_done   = 1'b0;
    case (state)
      IDLE:       if (i_en) state_next = WAIT_VS;
      WAIT_VS:    if (vs_q) state_next = WAIT_START;
      WAIT_START: if (vs_fall) begin
        state_next   = ACTIVE;
        enter_active = 1'b1;
      end
      ACTIVE: begin
        if (vs_q) begin
          abort      = 1'b1;
          state_next = WAIT_START;
        end else begin
          // A rising HREF always carries the first byte of a pair, whatever phase was left over.
          if (hr_rise) begin
            line_start = 1'b1;
            byte_store = 1'b1;
          end else if (hr_q && in_line) begin
            if (phase) pix_wr = 1'b1;
            else       byte_store = 1'b1;
          end
          if (hr_fall && in_line) begin
            line_end = 1'b1;
            if (y_cnt == Y_LAST) begin
              frame_done = 1'b1;
              state_next = WAIT_VS;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_cam_pclk) begin
    if (i_rst) begin
      state       <= IDLE;
      vs_q        <= 1'b0;
      vs_qq       <= 1'b0;
      hr_q        <= 1'b0;
      hr_qq       <= 1'b0;
      d_q         <= '0;
      phase       <= 1'b0;
      in_line     <= 1'b0;
      byte0       <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      o_wr        <= 1'b0;
      o_wdata     <= '0;
      o_sof       <= 1'b0;
      o_eol       <= 1'b0;
      o_x         <= '0;
      o_y         <= '0;
      o_frame_cnt <= '0;
      o_err_len   <= 1'b0;
      o_err_ovf   <= 1'b0;
    end else begin
      state <= state_next;
      vs_q  <= i_cam_vsync;
      vs_qq <= vs_q;
      hr_q  <= i_cam_href;
      hr_qq <= hr_q;
      d_q   <= i_cam_data;
      o_wr  <= pix_wr;
      o_sof <= pix_wr && (x_cnt == '0) && (y_cnt == '0);
      o_eol <= pix_wr && (x_cnt == X_LAST);
      if (o_wr && i_fifo_full) o_err_ovf <= 1'b1;
      if (enter_active) begin
        y_cnt   <= '0;
        phase   <= 1'b0;
        in_line <= 1'b0;
      end
      if (abort) begin
        o_err_len <= 1'b1;
        phase     <= 1'b0;
        in_line   <= 1'b0;
      end
      if (line_start) begin
        x_cnt   <= '0;
        in_line <= 1'b1;
      end
      if (byte_store) begin
        byte0 <= d_q[3:0];
        phase <= 1'b1;
      end
      if (pix_wr) begin
        o_wdata <= {byte0, d_q};
        o_x     <= x_cnt[9:0];
        o_y     <= y_cnt;
        x_cnt   <= x_cnt + 11'd1;
        phase   <= 1'b0;
      end
      // A dangling first byte at line end is dropped and flagged as an odd count.
      if (line_end) begin
        y_cnt   <= y_cnt + 9'd1;
        phase   <= 1'b0;
        in_line <= 1'b0;
        if ((x_cnt != X_FULL) || phase) o_err_len <= 1'b1;
      end
      if (frame_done) o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a small 8x4 frame: driver tasks push expected
// pixels into a queue, a negedge monitor pops and compares every o_wr.
module tb_cam_capture;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst, en, vsync, href, full;
  logic [7:0]  data;
  logic        o_wr, o_sof, o_eol, o_err_len, o_err_ovf;
  logic [11:0] o_wdata;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic [15:0] o_frame_cnt;

  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  int sof_seen = 0;
  int eol_seen = 0;
  logic [32:0] exp_q[$];
  logic [11:0] pat_base = 12'h000;

  cam_capture #(.H_PIXELS(H), .V_LINES(V)) dut (
    .i_cam_pclk(clk), .i_rst(rst), .i_en(en), .i_cam_vsync(vsync),
    .i_cam_href(href), .i_cam_data(data), .i_fifo_full(full),
    .o_wr(o_wr), .o_wdata(o_wdata), .o_sof(o_sof), .o_eol(o_eol),
    .o_x(o_x), .o_y(o_y), .o_frame_cnt(o_frame_cnt),
    .o_err_len(o_err_len), .o_err_ovf(o_err_ovf)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vsync();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  // Pixel (x,y) = x*(y+1) + pat_base; byte0 = {F, R}, byte1 = {G, B}.
  task automatic send_line(input int y, input int nbytes, input bit push, input bit lat, input bit keep);
    logic [11:0] pix;
    for (int b = 0; b < nbytes; b++) begin
      pix  = 12'((b / 2) * (y + 1)) + pat_base;
      href = 1'b1;
      data = (b % 2 == 0) ? {4'hF, pix[11:8]} : pix[7:0];
      if (push && (b % 2 == 1))
        exp_q.push_back({pix, 10'(b / 2), 9'(y), (b / 2 == 0) && (y == 0), (b / 2 == H - 1)});
      tick();
      if (lat && b == 1) check("lat_no_early_wr", 64'(o_wr), 64'd0);
      if (lat && b == 2) begin
        check("lat_wr", 64'(o_wr), 64'd1);
        check("lat_wdata", 64'(o_wdata), 64'h5A3);
        check("lat_xy", {o_x, o_y}, 64'd0);
        check("lat_sof", 64'(o_sof), 64'd1);
      end
    end
    if (!keep) begin
      href = 1'b0;
      data = 8'h00;
      repeat (3) tick();
    end
  endtask

  task automatic send_frame();
    send_vsync();
    for (int y = 0; y < V; y++) send_line(y, 2 * H, 1'b1, 1'b0, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [32:0] exp;
    if (!rst && !o_wr && (o_sof || o_eol)) begin
      checks++;
      failures++;
      $display("FAIL stray_marker sof=%0b eol=%0b required=0", o_sof, o_eol);
    end
    if (!rst && o_wr) begin
      wr_seen++;
      sof_seen += int'(o_sof);
      eol_seen += int'(o_eol);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pixel actual=%0h x=%0d y=%0d required=none", o_wdata, o_x, o_y);
      end else begin
        exp = exp_q.pop_front();
        check("pixel", 64'({o_wdata, o_x, o_y, o_sof, o_eol}), 64'(exp));
      end
    end
  end

  initial begin
    int w0;
    rst = 1'b1; en = 1'b0; vsync = 1'b0; href = 1'b0; full = 1'b0; data = 8'h00;
    repeat (3) tick();
    check("reset_outputs", {o_wr, o_sof, o_eol, o_err_len, o_err_ovf, o_wdata, o_x, o_y}, 64'd0);
    check("reset_frame_cnt", 64'(o_frame_cnt), 64'd0);
    rst = 1'b0;
    en = 1'b1;
    repeat (2) tick();

    // full frame with the x*(y+1) pattern
    w0 = wr_seen;
    send_frame();
    check("frame1_pixels", 64'(wr_seen - w0), 64'(H * V));
    check("frame1_sof", 64'(sof_seen), 64'd1);
    check("frame1_eol", 64'(eol_seen), 64'(V));
    check("frame1_cnt", 64'(o_frame_cnt), 64'd1);
    check("frame1_errs", {o_err_len, o_err_ovf}, 64'd0);
    check("frame1_drained", 64'(exp_q.size()), 64'd0);

    // first pair 0xF5,0xA3 -> 0x5A3 one cycle after the edge sampling 0xA3
    pat_base = 12'h5A3;
    send_vsync();
    send_line(0, 2 * H, 1'b1, 1'b1, 1'b0);
    for (int y = 1; y < V; y++) send_line(y, 2 * H, 1'b1, 1'b0, 1'b0);
    pat_base = 12'h000;
    check("frame2_cnt", 64'(o_frame_cnt), 64'd2);

    // early VSYNC after two lines aborts the frame
    send_vsync();
    send_line(0, 2 * H, 1'b1, 1'b0, 1'b0);
    send_line(1, 2 * H, 1'b1, 1'b0, 1'b0);
    w0 = wr_seen;
    send_frame();
    check("early_vs_err_len", 64'(o_err_len), 64'd1);
    check("early_vs_next_pixels", 64'(wr_seen - w0), 64'(H * V));
    check("early_vs_cnt", 64'(o_frame_cnt), 64'd3);

    // reset mid-line, then capture only after a fresh VSYNC
    send_vsync();
    send_line(0, 2 * H, 1'b1, 1'b0, 1'b0);
    send_line(1, 5, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst_outputs", {o_wr, o_sof, o_eol, o_err_len, o_err_ovf, o_wdata, o_x, o_y}, 64'd0);
    check("midrst_frame_cnt", 64'(o_frame_cnt), 64'd0);
    rst = 1'b0;
    href = 1'b0;
    data = 8'h00;
    exp_q.delete();
    repeat (3) tick();
    w0 = wr_seen;
    send_line(0, 2 * H, 1'b0, 1'b0, 1'b0);
    send_line(1, 2 * H, 1'b0, 1'b0, 1'b0);
    check("no_capture_without_vsync", 64'(wr_seen - w0), 64'd0);
    send_frame();
    check("post_rst_pixels", 64'(wr_seen - w0), 64'(H * V));
    check("post_rst_cnt", 64'(o_frame_cnt), 64'd1);
    check("post_rst_errs", {o_err_len, o_err_ovf}, 64'd0);

    // odd/short line 2: one byte short
    w0 = wr_seen;
    send_vsync();
    send_line(0, 2 * H, 1'b1, 1'b0, 1'b0);
    send_line(1, 2 * H, 1'b1, 1'b0, 1'b0);
    check("short_err_before", 64'(o_err_len), 64'd0);
    send_line(2, 2 * H - 1, 1'b1, 1'b0, 1'b0);
    check("short_err_after", 64'(o_err_len), 64'd1);
    send_line(3, 2 * H, 1'b1, 1'b0, 1'b0);
    check("short_pixels", 64'(wr_seen - w0), 64'(H * V - 1));
    check("short_cnt", 64'(o_frame_cnt), 64'd2);
    check("short_drained", 64'(exp_q.size()), 64'd0);

    // FIFO full for 10 cycles mid-line
    send_vsync();
    send_line(0, 2 * H, 1'b1, 1'b0, 1'b0);
    check("ovf_before", 64'(o_err_ovf), 64'd0);
    fork
      send_line(1, 2 * H, 1'b1, 1'b0, 1'b0);
      begin
        repeat (3) tick();
        full = 1'b1;
        repeat (10) tick();
        full = 1'b0;
      end
    join
    check("ovf_set", 64'(o_err_ovf), 64'd1);
    send_line(2, 2 * H, 1'b1, 1'b0, 1'b0);
    send_line(3, 2 * H, 1'b1, 1'b0, 1'b0);
    check("ovf_sticky", 64'(o_err_ovf), 64'd1);
    check("ovf_cnt", 64'(o_frame_cnt), 64'd3);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
# cam_capture

Pixel capture front end for the OV7670 video path. It runs in the camera pixel-clock domain and samples the sensor's VSYNC/HREF/8-bit data bus. It pairs bytes into 12-bit RGB444 pixels and writes them into the asynchronous pixel FIFO that feeds the display/HDMI stage. It also tracks frame and line position and flags protocol errors (bad line length, odd byte count, FIFO overflow).

## Interface
Parameters:
- H_PIXELS, 640, pixels per line (bytes per line = 2*H_PIXELS)
- V_LINES, 480, lines per frame
- Ports (clock and reset first):
- i_cam_pclk  in  1  camera pixel clock; sole clock of the block
- i_rst  in  1  reset, synchronous to i_cam_pclk, active-high
- i_en  in  1  capture enable; sampled only in IDLE
- i_cam_vsync  in  1  sensor VSYNC, active-high pulse between frames
- i_cam_href  in  1  sensor HREF, high during valid line bytes
- i_cam_data  in  8  sensor data byte
- i_fifo_full  in  1  pixel FIFO full
- o_wr  out  1  FIFO write strobe, one cycle per pixel
- o_wdata  out  12  pixel {R[3:0],G[3:0],B[3:0]}
- o_sof  out  1  one-cycle pulse with the first pixel of a frame
- o_eol  out  1  one-cycle pulse with the last pixel of each line
- o_x  out  10  column of the pixel on o_wdata
- o_y  out  9  row of the pixel on o_wdata
- o_frame_cnt  out  16  completed frames, wraps at 0xFFFF
- o_err_len  out  1  sticky; a line ended with a wrong or odd byte count
- o_err_ovf  out  1  sticky; a pixel was written while i_fifo_full was high

## Operation
- Input stage: i_cam_vsync, i_cam_href and i_cam_data are registered once on the rising edge of i_cam_pclk (vs_q, hr_q, d_q). All logic uses the registered copies. vs_q and hr_q are also kept one cycle further (vs_qq, hr_qq) for edge detection.
- State machine:
  - IDLE: go to WAIT_VS when i_en=1.
  - WAIT_VS: go to WAIT_START when vs_q=1.
  - WAIT_START: go to ACTIVE on the VSYNC falling edge (vs_qq=1, vs_q=0).
  - ACTIVE: on the falling edge of the last line's HREF (y = V_LINES-1), increment o_frame_cnt and go to WAIT_VS. i_en is ignored, so a frame is never cut short.
  - If vs_q=1 while in ACTIVE (early VSYNC), abort the frame: set o_err_len, do not increment o_frame_cnt, go to WAIT_START.
- Byte pairing (ACTIVE only): a byte phase toggle resets to 0 on each HREF rising edge.
  - Phase 0 (hr_q=1): store byte0 and set phase to 1.
  - Phase 1: the pixel is {byte0[3:0], d_q}. Assert o_wr and set phase to 0.
  - byte0[7:4] is ignored.
- Counters:
  - x increments per pixel and clears at each HREF rising edge.
  - y increments at each HREF falling edge and clears on entry to ACTIVE.
  - o_x and o_y are registered together with o_wdata.
- Line check at the HREF falling edge: if pixel count ≠ H_PIXELS, or the phase is 1 (odd byte count), set o_err_len. The incomplete byte is discarded.
- o_sof is asserted with the pixel where x=0 and y=0.
- o_eol is asserted with the pixel where x=H_PIXELS-1.
- Overflow: if o_wr would assert while i_fifo_full=1, still pulse o_wr (the FIFO drops the pixel) and set o_err_ovf. Counters are unaffected.
- Sticky flags clear only on i_rst.

## Timing
- Reset values:
  - State = IDLE.
  - o_wr, o_sof, o_eol, o_err_len, o_err_ovf = 0.
  - o_wdata, o_x, o_y, o_frame_cnt = 0.
  - Phase = 0; vs_q, vs_qq, hr_q, hr_qq = 0.
- Reset mid-frame returns to IDLE on the same edge. No partial output follows.
- Latency: if the second byte of a pair is on the bus at rising edge E, then o_wr, o_wdata, o_x, o_y, o_sof and o_eol are registered at edge E+1 and valid for exactly one cycle.
- o_wr duty: at most every other cycle. No back-pressure: pixels are never stalled.
- At least 2 pclk cycles of VSYNC-low are required before the first HREF of a frame; HREF arriving during WAIT_START is ignored.
- o_frame_cnt updates at the edge after the last line's HREF fall is sampled.

## Test plan
- Single 640x480 frame, pixel (x,y) = 12'(x*(y+1)), byte0 upper nibble 0xF: 307200 o_wr pulses, each o_wdata matches in order. o_sof once, o_eol 480 times, o_frame_cnt 0→1, no error flags.
- Latency: byte pair 0xF5,0xA3 as the first pair of a frame: o_wr high exactly one cycle after the edge sampling 0xA3, o_wdata=0x5A3, o_x=0, o_y=0, o_sof=1.
- Short/odd line: line 3 carries 1279 bytes: o_err_len=1 after line 3. Line 4 still starts at x=0 and captures correctly; only 639 pixels are written for line 3.
- Overflow: hold i_fifo_full=1 for 10 cycles mid-line: o_err_ovf=1 and stays 1. o_x continues incrementing with no skipped values.
- Early VSYNC at line 200: no frame_cnt increment, o_err_len=1. The next full frame captures 307200 pixels and o_frame_cnt increments.
- i_rst pulse mid-line, then i_en=1: all outputs 0 the cycle after reset. Capture resumes only after a full VSYNC high→low sequence.
